// File: rtl/spi_master_cfg.sv
// Configurable SPI master behind an Avalon-MM register slave.
// Build-time frame width and slave count; mode, bit order, divider and irq enable set at run time.
`timescale 1ns/1ps

module spi_master_cfg #(
    parameter int NUMBER_SLAVES = 1,
    parameter int DATA_WIDTH    = 32,
    parameter int DIV_WIDTH     = 8,
    parameter int DEFAULT_DIV   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     sclk,
    output logic                     mosi,
    input  logic                     miso,
    output logic [NUMBER_SLAVES-1:0] ss_n,
    output logic                     irq,
    input  logic [2:0]               avs_address,
    input  logic                     avs_read,
    output logic [31:0]              avs_readdata,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata
);

    localparam int EW = $clog2(2 * DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t state, next_state;

    logic                     cpol, cpha, lsb_first, irq_en;
    logic [DIV_WIDTH-1:0]     divider;
    logic [31:0]              slave_sel;
    logic [DATA_WIDTH-1:0]    rx_data;
    logic                     done;

    logic                     cpha_q, lsb_q;
    logic [DIV_WIDTH-1:0]     div_q;
    logic [DIV_WIDTH-1:0]     div_cnt;
    logic [EW-1:0]            edge_cnt;
    logic                     sclk_q;
    logic [DATA_WIDTH-1:0]    tx_shift, rx_shift;

    logic                     busy, start, rd_rx, tick, last_edge;
    logic                     edge_now, leading, sample_now, drive_now, finish;
    logic [DATA_WIDTH-1:0]    tx_word;
    logic [NUMBER_SLAVES-1:0] ss_sel;
    logic [31:0]              rd_mux;

    assign busy      = (state != IDLE);
    assign start     = avs_write && (avs_address == 3'd2) && (state == IDLE);
    assign rd_rx     = avs_read && (avs_address == 3'd3);
    assign tx_word   = avs_writedata[DATA_WIDTH-1:0];
    assign tick      = (div_cnt == div_q);
    assign last_edge = (edge_cnt == EW'(2 * DATA_WIDTH));

    // Edges are numbered from 1; odd edges lead, even edges trail. The final
    // trailing edge never drives a new bit because the frame is already out.
    assign edge_now   = tick && ((state == SETUP) || ((state == SHIFT) && !last_edge));
    assign leading    = ~edge_cnt[0];
    assign sample_now = edge_now && (leading ^ cpha_q);
    assign drive_now  = edge_now && !(leading ^ cpha_q) &&
                        (edge_cnt != EW'(2 * DATA_WIDTH - 1));
    assign finish     = (state == HOLD) && tick;

    assign sclk = (state == IDLE) ? cpol : sclk_q;

    always_comb begin
        ss_sel = '1;
        for (int i = 0; i < NUMBER_SLAVES; i++) begin
            if (slave_sel == 32'(i)) begin
                ss_sel[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)             next_state = SETUP;
            SETUP:   if (tick)              next_state = SHIFT;
            SHIFT:   if (tick && last_edge) next_state = HOLD;
            HOLD:    if (tick)              next_state = IDLE;
            default:                        next_state = IDLE;
        endcase
    end

    // Configuration registers are frozen while a frame is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpol      <= 1'b0;
            cpha      <= 1'b0;
            lsb_first <= 1'b0;
            irq_en    <= 1'b0;
            divider   <= DIV_WIDTH'(DEFAULT_DIV);
            slave_sel <= 32'd0;
        end else if (avs_write && !busy) begin
            case (avs_address)
                3'd0: {irq_en, lsb_first, cpha, cpol} <= avs_writedata[3:0];
                3'd1: divider   <= avs_writedata[DIV_WIDTH-1:0];
                3'd4: slave_sel <= avs_writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q   <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            div_q    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            done     <= 1'b0;
            irq      <= 1'b0;
        end else begin
            irq <= done & irq_en;

            if ((state == IDLE) || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_WIDTH'(1);
            end

            if (start) begin
                cpha_q   <= cpha;
                lsb_q    <= lsb_first;
                div_q    <= divider;
                sclk_q   <= cpol;
                ss_n     <= ss_sel;
                edge_cnt <= '0;
                rx_shift <= '0;
                // With CPHA=0 the first bit must be on mosi before the first edge.
                if (cpha) begin
                    tx_shift <= tx_word;
                end else if (lsb_first) begin
                    mosi     <= tx_word[0];
                    tx_shift <= tx_word >> 1;
                end else begin
                    mosi     <= tx_word[DATA_WIDTH-1];
                    tx_shift <= tx_word << 1;
                end
            end

            if (edge_now) begin
                sclk_q   <= ~sclk_q;
                edge_cnt <= edge_cnt + EW'(1);
            end

            if (drive_now) begin
                mosi     <= lsb_q ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
                tx_shift <= lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
            end

            if (sample_now) begin
                rx_shift <= lsb_q ? {miso, rx_shift[DATA_WIDTH-1:1]}
                                  : {rx_shift[DATA_WIDTH-2:0], miso};
            end

            if (finish) begin
                ss_n    <= '1;
                rx_data <= rx_shift;
            end

            if (finish) begin
                done <= 1'b1;
            end else if (start || rd_rx) begin
                done <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (avs_address)
            3'd0:    rd_mux = {28'd0, irq_en, lsb_first, cpha, cpol};
            3'd1:    rd_mux = 32'(divider);
            3'd3:    rd_mux = 32'(rx_data);
            3'd4:    rd_mux = slave_sel;
            3'd5:    rd_mux = {30'd0, done, busy};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avs_readdata <= 32'd0;
        end else begin
            avs_readdata <= avs_read ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg: stimulus queues expected reads, mosi bits and frames;
// a negedge monitor pops and compares as the DUT produces them.
`timescale 1ns/1ps

module tb_spi_master_cfg;

    localparam int NS = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          sclk, mosi, miso, irq;
    logic [NS-1:0] ss_n;
    logic [2:0]    avs_address;
    logic          avs_read, avs_write;
    logic [31:0]   avs_readdata, avs_writedata;

    spi_master_cfg #(
        .NUMBER_SLAVES(NS),
        .DATA_WIDTH   (DW),
        .DIV_WIDTH    (8),
        .DEFAULT_DIV  (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sclk         (sclk),
        .mosi         (mosi),
        .miso         (miso),
        .ss_n         (ss_n),
        .irq          (irq),
        .avs_address  (avs_address),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        int          len;
        logic [NS-1:0] ss;
    } frame_exp_t;

    rd_exp_t    rd_q[$];
    bit         mosi_q[$];
    frame_exp_t frame_q[$];

    int total = 0;
    int bad   = 0;

    logic       rd_valid;
    bit         mon_en   = 1'b0;
    bit         loopback = 1'b1;
    bit         tb_cpol  = 1'b0, tb_cpha = 1'b0, tb_lsb = 1'b0;
    logic       slave_bit = 1'b0;
    logic [7:0] slave_word = 8'h00;
    int         slave_idx = 0;

    assign miso = loopback ? mosi : slave_bit;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Read data is valid the cycle after the strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) rd_valid <= 1'b0;
        else       rd_valid <= avs_read;
    end

    logic       prev_sclk = 1'b0;
    int         low_cnt = 0;
    logic [NS-1:0] first_ss;
    bit         lead_edge;
    rd_exp_t    cur_rd;
    frame_exp_t cur_fr;
    bit         cur_bit;

    always @(negedge clk) begin
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                checkOutput("unexpected_read", 32'd1, 32'd0);
            end else begin
                cur_rd = rd_q.pop_front();
                checkOutput(cur_rd.name, avs_readdata, cur_rd.val);
            end
        end

        if (!mon_en || reset) begin
            low_cnt = 0;
        end else if (ss_n != '1) begin
            if (low_cnt == 0) first_ss = ss_n;
            low_cnt++;
        end else if (low_cnt != 0) begin
            if (frame_q.size() == 0) begin
                checkOutput("unexpected_frame", 32'd1, 32'd0);
            end else begin
                cur_fr = frame_q.pop_front();
                checkOutput("frame_len", 32'(low_cnt), 32'(cur_fr.len));
                checkOutput("frame_ss", 32'(first_ss), 32'(cur_fr.ss));
            end
            low_cnt = 0;
        end

        if (mon_en && !reset && ss_n != '1 && sclk != prev_sclk) begin
            lead_edge = (sclk != tb_cpol);
            if (lead_edge ^ tb_cpha) begin
                if (mosi_q.size() == 0) begin
                    checkOutput("unexpected_mosi", 32'd1, 32'd0);
                end else begin
                    cur_bit = mosi_q.pop_front();
                    checkOutput("mosi_bit", 32'(mosi), 32'(cur_bit));
                end
            end else if (!loopback && slave_idx < DW) begin
                slave_bit = tb_lsb ? slave_word[slave_idx] : slave_word[DW-1-slave_idx];
                slave_idx++;
            end
        end
        prev_sclk = sclk;
    end

    // Bus tasks are entered on a negedge and return on the following negedge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        avs_write     = 1'b1;
        avs_address   = addr;
        avs_writedata = data;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic readExpect(input logic [2:0] addr, input logic [31:0] exp, input string nm);
        rd_exp_t e;
        e.name = nm;
        e.val  = exp;
        rd_q.push_back(e);
        avs_read    = 1'b1;
        avs_address = addr;
        @(negedge clk);
        avs_read    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pushMosi(input logic [7:0] w, input bit lsb);
        for (int i = 0; i < DW; i++) begin
            mosi_q.push_back(lsb ? w[i] : w[DW-1-i]);
        end
    endtask

    task automatic expectFrame(input int len, input logic [NS-1:0] ss);
        frame_exp_t f;
        f.len = len;
        f.ss  = ss;
        frame_q.push_back(f);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        avs_address   = 3'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_sclk", 32'(sclk), 32'd0);
        checkOutput("rst_mosi", 32'(mosi), 32'd0);
        checkOutput("rst_ss_n", 32'(ss_n), 32'hF);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_readdata", avs_readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        readExpect(3'd1, 32'd1, "div_reset");
        readExpect(3'd0, 32'd0, "ctrl_reset");
        readExpect(3'd5, 32'd0, "status_reset");
        readExpect(3'd4, 32'd0, "ss_reset");
        readExpect(3'd6, 32'd0, "unmapped_addr");

        // Mode 0, H=1, loopback, upper TX bits must be dropped.
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd4, 32'd0);
        pushMosi(8'hA5, 1'b0);
        expectFrame(18, 4'b1110);
        applyStimulus(3'd2, 32'hFFFF_FFA5);
        readExpect(3'd5, 32'd1, "status_busy_m0");
        idle(25);
        readExpect(3'd5, 32'd2, "status_done_m0");
        readExpect(3'd3, 32'hA5, "rx_mode0");
        readExpect(3'd5, 32'd0, "status_cleared_m0");

        // Mode 3, LSB first, H=4, slave returns 0x81; busy writes ignored.
        tb_cpol = 1'b1; tb_cpha = 1'b1; tb_lsb = 1'b1;
        loopback = 1'b0; slave_word = 8'h81; slave_idx = 0; slave_bit = 1'b0;
        applyStimulus(3'd0, 32'd7);
        checkOutput("sclk_idle_high", 32'(sclk), 32'd1);
        applyStimulus(3'd1, 32'd3);
        pushMosi(8'h3C, 1'b1);
        expectFrame(72, 4'b1110);
        applyStimulus(3'd2, 32'h3C);
        idle(10);
        applyStimulus(3'd2, 32'hFF);
        applyStimulus(3'd1, 32'd0);
        readExpect(3'd5, 32'd1, "status_busy_m3");
        readExpect(3'd1, 32'd3, "div_unchanged");
        idle(80);
        readExpect(3'd3, 32'h81, "rx_mode3");

        // Slave select decoding, including an out-of-range index.
        tb_cpol = 1'b0; tb_cpha = 1'b0; tb_lsb = 1'b0; loopback = 1'b1;
        applyStimulus(3'd0, 32'd0);
        applyStimulus(3'd1, 32'd0);
        applyStimulus(3'd4, 32'd2);
        pushMosi(8'h5A, 1'b0);
        expectFrame(18, 4'b1011);
        applyStimulus(3'd2, 32'h5A);
        idle(25);
        readExpect(3'd3, 32'h5A, "rx_ss2");
        applyStimulus(3'd4, 32'd5);
        applyStimulus(3'd2, 32'h00);
        idle(5);
        checkOutput("ss5_mid_high", 32'(ss_n), 32'hF);
        readExpect(3'd5, 32'd1, "status_busy_ss5");
        idle(20);
        checkOutput("ss5_end_high", 32'(ss_n), 32'hF);
        readExpect(3'd5, 32'd2, "status_done_ss5");
        readExpect(3'd3, 32'd0, "rx_ss5");

        // Interrupt follows done by one cycle and drops after an RX read.
        applyStimulus(3'd4, 32'd0);
        applyStimulus(3'd0, 32'd8);
        pushMosi(8'hC3, 1'b0);
        expectFrame(18, 4'b1110);
        applyStimulus(3'd2, 32'hC3);
        n = 0;
        while (ss_n != 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("irq_frame_end_seen", 32'(n < 100), 32'd1);
        checkOutput("irq_with_done", 32'(irq), 32'd0);
        @(negedge clk);
        checkOutput("irq_rise", 32'(irq), 32'd1);
        readExpect(3'd3, 32'hC3, "rx_irq");
        checkOutput("irq_still_high", 32'(irq), 32'd1);
        @(negedge clk);
        checkOutput("irq_fall", 32'(irq), 32'd0);

        // Reset in the middle of a shift, then a clean transfer at the default divider.
        applyStimulus(3'd0, 32'd0);
        mon_en = 1'b0;
        applyStimulus(3'd1, 32'd3);
        applyStimulus(3'd2, 32'hFF);
        idle(20);
        reset = 1'b1;
        #1;
        checkOutput("async_rst_ss_n", 32'(ss_n), 32'hF);
        checkOutput("async_rst_sclk", 32'(sclk), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ss_n", 32'(ss_n), 32'hF);
        checkOutput("post_rst_sclk", 32'(sclk), 32'd0);
        checkOutput("post_rst_mosi", 32'(mosi), 32'd0);
        checkOutput("post_rst_irq", 32'(irq), 32'd0);
        readExpect(3'd5, 32'd0, "status_after_reset");
        readExpect(3'd3, 32'd0, "rx_after_reset");
        readExpect(3'd1, 32'd1, "div_after_reset");
        mon_en = 1'b1;
        pushMosi(8'h96, 1'b0);
        expectFrame(36, 4'b1110);
        applyStimulus(3'd2, 32'h96);
        idle(45);
        readExpect(3'd3, 32'h96, "rx_after_reset_xfer");
        readExpect(3'd5, 32'd0, "status_final");

        idle(3);
        checkOutput("rd_q_drained", 32'(rd_q.size()), 32'd0);
        checkOutput("mosi_q_drained", 32'(mosi_q.size()), 32'd0);
        checkOutput("frame_q_drained", 32'(frame_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_master_cfg.md
# spi_master_cfg

Parametrised SPI master with an Avalon-MM slave register interface, the configurable successor to the fixed 32-bit, mode-0, divide-by-2 SPI master. Frame width, slave count and divider width are set at build time. SPI mode (CPOL/CPHA), bit order, sclk divider and interrupt enable are run-time registers. Adds busy/done status and a completion interrupt so software can poll or wait on transfers.

## Interface
- NUMBER_SLAVES, 1: number of ss_n lines (1..32)
- DATA_WIDTH, 32: frame length in bits (4..32)
- DIV_WIDTH, 8: width of the DIVIDER register
- DEFAULT_DIV, 1: reset value of DIVIDER
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- sclk  out  1  SPI serial clock
- mosi  out  1  serial data out
- miso  in  1  serial data in, sampled on clk
- ss_n  out  NUMBER_SLAVES  active-low slave selects
- irq  out  1  done & CONTROL.IRQ_EN, registered
- avs_address  in  3  register word address
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid one cycle after avs_read
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data

## Operation
- Registers: 0 CONTROL {bit0 CPOL, bit1 CPHA, bit2 LSB_FIRST, bit3 IRQ_EN}, reset 0. 1 DIVIDER [DIV_WIDTH-1:0], reset DEFAULT_DIV. 2 TX_DATA [DATA_WIDTH-1:0], write starts a transfer. 3 RX_DATA, read-only. 4 SLAVE_SELECT index, reset 0. 5 STATUS {bit0 busy, bit1 done}, read-only. Other addresses read 0; unused bits read 0; avs_write takes precedence over nothing (read and write in same cycle: write performed, read data still returned).
- Half-period H = DIVIDER+1 clk cycles.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE: sclk = CPOL (tracks CONTROL immediately). A write to TX_DATA loads the shift register, latches the mode/divider/select config, clears done, sets busy and enters SETUP.
- SETUP: ss_n[SLAVE_SELECT] = 0 for H cycles; if CPHA=0, the first bit is driven on mosi on entry.
- SHIFT: 2*DATA_WIDTH sclk edges, one every H cycles. CPHA=0: sample miso on leading edges, drive next bit on trailing edges (except the last). CPHA=1: drive on leading edges, sample on trailing edges.
- Bit order: MSB first unless LSB_FIRST=1.
- HOLD: sclk at CPOL, ss_n still low for H cycles. Then ss_n goes high, the RX shift register is copied to RX_DATA (zero-extended), done=1, busy=0, and the FSM returns to IDLE.
- Writes to CONTROL, DIVIDER, SLAVE_SELECT or TX_DATA while busy are ignored.
- done clears on a read of RX_DATA or on a new TX_DATA write.
- SLAVE_SELECT >= NUMBER_SLAVES: the transfer runs, but every ss_n stays high.
- TX_DATA bits above DATA_WIDTH are ignored.

## Timing
- Reset values (immediate, including mid-transfer): sclk=0, mosi=0, ss_n all 1, irq=0, avs_readdata=0. FSM returns to IDLE and RX_DATA=0.
- TX_DATA write accepted on edge T: busy=1 and ss_n low from T+1.
- First sclk edge at T+1+H.
- Last edge at T+1+2*DATA_WIDTH*H.
- ss_n high and done=1 at T+1+(2*DATA_WIDTH+2)*H.
- irq follows done one cycle later.
- Back-to-back: a TX_DATA write in the first cycle after busy falls is accepted; ss_n is high for at least 1 cycle between frames.
- miso is sampled in the same clk cycle that sclk toggles to the sampling edge.

## Test plan
- Reset mid-SHIFT -> next cycle: ss_n all 1, sclk=0, busy=0, RX_DATA=0; a subsequent transfer completes normally.
- Mode 0, DIVIDER=0, DATA_WIDTH=8, TX=0xA5, miso loopback -> mosi MSB-first 1,0,1,0,0,1,0,1; RX_DATA=0xA5; busy high for exactly 18 cycles.
- Mode 3 (CPOL=1, CPHA=1), DIVIDER=3, LSB_FIRST=1, TX=0x3C, slave returns 0x81 -> sclk idles high, H=4 cycles, mosi sequence 0,0,1,1,1,1,0,0, RX_DATA=0x81.
- SLAVE_SELECT=2 with NUMBER_SLAVES=4 -> only ss_n[2] low. SLAVE_SELECT=5 -> ss_n stays 4'hF and done still sets.
- TX_DATA and DIVIDER writes while busy -> ignored; frame and timing unchanged; STATUS reads busy=1.
- IRQ_EN=1 -> irq rises one cycle after done; a RX_DATA read clears done, and irq falls the next cycle.
